// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch design: clock rate, debounce timing
// defaults and the bit positions of the board buttons and switches.
package stopwatch_pkg;

  localparam int CLK_HZ              = 100_000_000;
  localparam int DEBOUNCE_TICK_DIV   = 131072;
  localparam int DEBOUNCE_STABLE_CNT = 4;

  localparam int BTN_PAUSE = 0;
  localparam int SW_SEL    = 0;
  localparam int SW_ADJ_LO = 1;
  localparam int SW_ADJ_HI = 2;

endpackage

// File: rtl/debounce_channel.sv
// One input bit: two-flop synchroniser, integrate-to-N debounce evaluated on
// the shared sample tick, and registered rise/fall strobes.
module debounce_channel
  import stopwatch_pkg::*;
#(
  parameter int STABLE_CNT = DEBOUNCE_STABLE_CNT
) (
  input  logic clk_100mhz,
  input  logic rst_n,
  input  logic raw,
  input  logic sample_tick,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          level_next;
  logic          accept;

  // A sample that agrees with the current level restarts the count, so only
  // STABLE_CNT consecutive disagreeing samples can move the level.
  always_comb begin
    accept     = 1'b0;
    cnt_next   = cnt;
    level_next = level;
    if (sample_tick) begin
      if (sync2 == level) begin
        cnt_next = '0;
      end else if (cnt == LAST) begin
        accept     = 1'b1;
        level_next = sync2;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cnt   <= cnt_next;
      level <= level_next;
      rise  <= accept & sync2;
      fall  <= accept & ~sync2;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: shared debounce sample tick, one debounce channel
// per button and switch, button toggle state and switch change strobes.
module input_conditioner
  import stopwatch_pkg::*;
#(
  parameter int N_BTN      = 2,
  parameter int N_SW       = 3,
  parameter int TICK_DIV   = DEBOUNCE_TICK_DIV,
  parameter int STABLE_CNT = DEBOUNCE_STABLE_CNT
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_toggle,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_SW-1:0]  sw_changed,
  output logic             sample_tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]    tick_cnt;
  logic [N_BTN-1:0] toggle_q;
  logic [N_SW-1:0]  sw_rise;
  logic [N_SW-1:0]  sw_fall;

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= (tick_cnt == TICK_LAST);
      tick_cnt    <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_channel #(.STABLE_CNT(STABLE_CNT)) u_chan (
      .clk_100mhz  (clk_100mhz),
      .rst_n       (rst_n),
      .raw         (btn_raw[i]),
      .sample_tick (sample_tick),
      .level       (btn_level[i]),
      .rise        (btn_press[i]),
      .fall        (btn_release[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_channel #(.STABLE_CNT(STABLE_CNT)) u_chan (
      .clk_100mhz  (clk_100mhz),
      .rst_n       (rst_n),
      .raw         (sw_raw[i]),
      .sample_tick (sample_tick),
      .level       (sw_level[i]),
      .rise        (sw_rise[i]),
      .fall        (sw_fall[i])
    );
  end

  assign sw_changed = sw_rise | sw_fall;

  // toggle_q absorbs each press one cycle late; XOR with the press strobe makes
  // the visible toggle flip on the same edge the press strobe rises.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ btn_press;
    end
  end

  assign btn_toggle = toggle_q ^ btn_press;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with a short tick: cycle-by-cycle comparison
// against a sample-history reference model, plus table and directed cases.
module tb_input_conditioner;

  localparam int NB = 2;
  localparam int NS = 3;
  localparam int TD = 4;
  localparam int SC = 3;
  localparam int W  = NB + NS;

  logic          clk_100mhz = 1'b0;
  logic          rst_n      = 1'b0;
  logic [NB-1:0] btn_raw    = '0;
  logic [NS-1:0] sw_raw     = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_toggle;
  logic [NS-1:0] sw_level, sw_changed;
  logic          sample_tick;

  always #5 clk_100mhz = ~clk_100mhz;

  input_conditioner #(.N_BTN(NB), .N_SW(NS), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .sw_raw      (sw_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_toggle  (btn_toggle),
    .sw_level    (sw_level),
    .sw_changed  (sw_changed),
    .sample_tick (sample_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges counted since reset release; raw history kept in a
  // queue, so the value seen by the integrator is simply the raw two edges ago.
  int            m_k;
  logic [W-1:0]  raw_q[$];
  logic [W-1:0]  m_lvl, m_up, m_dn;
  int            m_run[W];
  logic [NB-1:0] m_tog;
  logic          m_tick;

  task automatic model_reset();
    m_k = 0;
    raw_q.delete();
    m_lvl = '0; m_up = '0; m_dn = '0; m_tog = '0; m_tick = 1'b0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    if (!rst_n) return;
    m_k++;
    raw_q.push_back({btn_raw, sw_raw});
    m_up = '0;
    m_dn = '0;
    if (m_tick) begin
      s = (m_k >= 3) ? raw_q[m_k-3] : '0;
      for (int i = 0; i < W; i++) begin
        if (s[i] !== m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == SC) begin
            m_lvl[i] = s[i];
            if (s[i]) m_up[i] = 1'b1; else m_dn[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    m_tog  = m_tog ^ m_up[W-1:NS];
    m_tick = (m_k % TD == 0);
  endtask

  task automatic compare_all();
    check("sample_tick", 32'(sample_tick), 32'(m_tick));
    check("btn_level",   32'(btn_level),   32'(m_lvl[W-1:NS]));
    check("btn_press",   32'(btn_press),   32'(m_up[W-1:NS]));
    check("btn_release", 32'(btn_release), 32'(m_dn[W-1:NS]));
    check("btn_toggle",  32'(btn_toggle),  32'(m_tog));
    check("sw_level",    32'(sw_level),    32'(m_lvl[NS-1:0]));
    check("sw_changed",  32'(sw_changed),  32'(m_up[NS-1:0] | m_dn[NS-1:0]));
  endtask

  // Strobe monitors for the directed sequences
  int            n_press[NB];
  int            n_rel[NB];
  int            n_swchg;
  logic [NS-1:0] sw_chg_seen;
  int            tog_bad;

  task automatic clear_mon();
    for (int i = 0; i < NB; i++) begin n_press[i] = 0; n_rel[i] = 0; end
    n_swchg = 0; sw_chg_seen = '0; tog_bad = 0;
  endtask

  task automatic step();
    logic [NB-1:0] tog_prev;
    tog_prev = btn_toggle;
    @(posedge clk_100mhz);
    model_edge();
    @(negedge clk_100mhz);
    compare_all();
    for (int i = 0; i < NB; i++) begin
      if (btn_press[i])   n_press[i]++;
      if (btn_release[i]) n_rel[i]++;
    end
    if (sw_changed != '0) n_swchg++;
    sw_chg_seen = sw_chg_seen | sw_changed;
    if (((btn_toggle ^ tog_prev) & ~btn_press) != '0) tog_bad++;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NB-1:0] btn;
    logic [NS-1:0] sw;
    int            hold;
    logic [NB-1:0] exp_btn;
    logic [NS-1:0] exp_sw;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2'b01, 3'b000, 20, 2'b01, 3'b000};
    vecs[1] = '{2'b11, 3'b010, 20, 2'b11, 3'b010};
    vecs[2] = '{2'b10, 3'b111, 20, 2'b10, 3'b111};
    vecs[3] = '{2'b00, 3'b100, 20, 2'b00, 3'b100};
    vecs[4] = '{2'b01, 3'b011, 20, 2'b01, 3'b011};
    vecs[5] = '{2'b00, 3'b000, 20, 2'b00, 3'b000};

    @(negedge clk_100mhz);

    // Reset/idle with both buttons held through reset
    btn_raw = 2'b11;
    do_reset(5);
    for (int e = 1; e <= 14; e++) begin
      step();
      check("tick_phase", 32'(sample_tick), 32'((e % 4) == 0));
      if (e == 12) check("idle_lvl_before", 32'(btn_level), 32'(2'b00));
      if (e == 13) begin
        check("idle_lvl_rise", 32'(btn_level),  32'(2'b11));
        check("idle_press",    32'(btn_press),  32'(2'b11));
        check("idle_toggle",   32'(btn_toggle), 32'(2'b11));
      end
      if (e == 14) check("idle_press_end", 32'(btn_press), 32'(2'b00));
    end

    // Glitch rejection: 2 ticks high, 1 tick low, five times
    btn_raw = 2'b00;
    do_reset(2);
    clear_mon();
    repeat (5) begin
      btn_raw[0] = 1'b1; hold(8);
      btn_raw[0] = 1'b0; hold(4);
    end
    hold(16);
    check("glitch_press_cnt", 32'(n_press[0]), 32'd0);
    check("glitch_level",     32'(btn_level[0]), 32'd0);
    check("glitch_toggle",    32'(btn_toggle[0]), 32'd0);

    // Press/release twice
    do_reset(2);
    clear_mon();
    for (int r = 0; r < 2; r++) begin
      btn_raw[0] = 1'b1; hold(20);
      check("pr_toggle_after_press", 32'(btn_toggle[0]), 32'(r == 0));
      btn_raw[0] = 1'b0; hold(20);
      check("pr_toggle_after_release", 32'(btn_toggle[0]), 32'(r == 0));
    end
    check("pr_press_cnt",   32'(n_press[0]), 32'd2);
    check("pr_release_cnt", 32'(n_rel[0]),   32'd2);
    check("pr_toggle_only_on_press", 32'(tog_bad), 32'd0);

    // Switch changes
    do_reset(2);
    clear_mon();
    sw_raw = 3'b101; hold(20);
    check("sw1_level",   32'(sw_level),    32'(3'b101));
    check("sw1_changed", 32'(sw_chg_seen), 32'(3'b101));
    check("sw1_cycles",  32'(n_swchg),     32'd1);
    clear_mon();
    sw_raw = 3'b001; hold(20);
    check("sw2_level",   32'(sw_level),    32'(3'b001));
    check("sw2_changed", 32'(sw_chg_seen), 32'(3'b100));
    check("sw2_cycles",  32'(n_swchg),     32'd1);

    // Reset in the middle of an integration
    sw_raw  = 3'b000;
    btn_raw = 2'b10;
    do_reset(2);
    hold(9);
    do_reset(1);
    for (int e = 1; e <= 13; e++) begin
      step();
      if (e == 12) check("midrst_before", 32'(btn_level[1]), 32'd0);
      if (e == 13) check("midrst_rise",   32'(btn_level[1]), 32'd1);
    end

    // Table-driven level vectors
    btn_raw = '0;
    sw_raw  = '0;
    do_reset(2);
    for (int v = 0; v < 6; v++) begin
      btn_raw = vecs[v].btn;
      sw_raw  = vecs[v].sw;
      hold(vecs[v].hold);
      check("vec_btn_level", 32'(btn_level), 32'(vecs[v].exp_btn));
      check("vec_sw_level",  32'(sw_level),  32'(vecs[v].exp_sw));
    end

    // Random bit flips with random hold times, one reset in the middle
    do_reset(3);
    for (int n = 0; n < 160; n++) begin
      btn_raw = btn_raw ^ NB'($urandom_range(0, 3));
      sw_raw  = sw_raw  ^ NS'($urandom_range(0, 7));
      hold($urandom_range(1, 24));
      if (n == 80) do_reset(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
